// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-wide data memory, with read-modify-write for sub-word stores.
// Optional misaligned-request error reporting is enabled by defining LSU_MISALIGN_ERR_EN.
`timescale 1ns/1ps
module load_store_unit #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_we,
   input  logic [1:0]              i_req_size,
   input  logic                    i_req_unsigned,
   input  logic [ADDR_WIDTH+1:0]   i_req_addr,
   input  logic [DATA_WIDTH-1:0]   i_req_wdata,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
   output logic                    o_rsp_err,
   output logic [ADDR_WIDTH-1:0]   o_mem_addr,
   output logic                    o_mem_wenable,
   output logic [DATA_WIDTH-1:0]   o_mem_wdata,
   input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
   output logic [2:0]              o_dbg_state
);

   // Request port: accepted on a clock edge where i_req_valid & o_req_ready; response port:
   // consumed on a clock edge where o_rsp_valid & i_rsp_ready; valid never depends on ready.
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW, S_STORE, S_RESP} state_e;

   state_e                  state_q;
   logic [1:0]              size_q;
   logic                    uns_q;
   logic [ADDR_WIDTH+1:0]   addr_q;
   logic [15:0]             wdata_q;
   logic                    rsp_valid_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic                    rsp_err_q;
   logic                    mem_we_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;

   logic [1:0]              req_off;
   logic                    req_err;
   logic [7:0]              ld_byte;
   logic [15:0]             ld_half;
   logic [DATA_WIDTH-1:0]   ld_ext;
   logic [DATA_WIDTH-1:0]   merged;

   assign o_req_ready   = (state_q == S_IDLE);
   assign o_rsp_valid   = rsp_valid_q;
   assign o_rsp_rdata   = rsp_rdata_q;
   assign o_rsp_err     = rsp_err_q;
   assign o_mem_addr    = addr_q[ADDR_WIDTH+1:2];
   assign o_mem_wenable = mem_we_q;
   assign o_mem_wdata   = mem_wdata_q;
   assign o_dbg_state   = state_q;

   // Without error reporting, offending low address bits are dropped so the access is aligned.
   always_comb begin
      req_off = i_req_addr[1:0];
      req_err = 1'b0;
      if (i_req_size == 2'b01) begin
`ifdef LSU_MISALIGN_ERR_EN
         req_err = i_req_addr[0];
`else
         req_off = {i_req_addr[1], 1'b0};
`endif
      end else if (i_req_size[1]) begin
`ifdef LSU_MISALIGN_ERR_EN
         req_err = |i_req_addr[1:0];
`else
         req_off = 2'b00;
`endif
      end
   end

   always_comb begin
      ld_byte = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      ld_half = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
      case (size_q)
         2'b00:   ld_ext = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
         2'b01:   ld_ext = {{16{ld_half[15] & ~uns_q}}, ld_half};
         default: ld_ext = i_mem_rdata;
      endcase
   end

   always_comb begin
      merged = i_mem_rdata;
      if (size_q == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else                 merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_req_valid) begin
                  size_q  <= i_req_size;
                  uns_q   <= i_req_unsigned;
                  addr_q  <= {i_req_addr[ADDR_WIDTH+1:2], req_off};
                  wdata_q <= i_req_wdata[15:0];
                  if (req_err) begin
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= '0;
                     rsp_err_q   <= 1'b1;
                     state_q     <= S_RESP;
                  end else if (!i_req_we) begin
                     state_q <= S_LOAD;
                  end else if (i_req_size[1]) begin
                     mem_wdata_q <= i_req_wdata;
                     mem_we_q    <= 1'b1;
                     state_q     <= S_STORE;
                  end else begin
                     state_q <= S_RMW;
                  end
               end
            end
            S_LOAD: begin
               rsp_rdata_q <= ld_ext;
               rsp_err_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RMW: begin
               mem_wdata_q <= merged;
               mem_we_q    <= 1'b1;
               state_q     <= S_STORE;
            end
            S_STORE: begin
               mem_we_q    <= 1'b0;
               rsp_rdata_q <= '0;
               rsp_err_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory; expectations are hand-computed.
// Build-dependent expectations follow LSU_MISALIGN_ERR_EN.
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'b00;
  logic        i_req_unsigned = 1'b0;
  logic [AW+1:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [AW-1:0] o_mem_addr;
  logic        o_mem_wenable;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic [2:0]  o_dbg_state;

  logic [31:0] mem [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_wenable(o_mem_wenable), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_dbg_state(o_dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;
  assign i_mem_rdata = mem[o_mem_addr];
  always @(posedge clk) begin
    if (o_mem_wenable) mem[o_mem_addr] <= o_mem_wdata;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk);
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issues one request with i_rsp_ready left as set by the caller; returns at the first cycle
  // showing o_rsp_valid (cycle numbers counted from the accept edge), or after 20 cycles.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [AW+1:0] addr, input logic [31:0] wdata,
                         output int rsp_cyc, output logic [31:0] rdata, output logic err,
                         output int we_cyc, output int we_cnt,
                         output logic [AW-1:0] w_addr, output logic [31:0] w_data);
    int cyc;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = we; i_req_size = size;
    i_req_unsigned = uns; i_req_addr = addr; i_req_wdata = wdata;
    @(posedge clk);
    rsp_cyc = -1; rdata = '0; err = 1'b0; we_cyc = -1; we_cnt = 0; w_addr = '0; w_data = '0;
    cyc = 0;
    while (rsp_cyc < 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) i_req_valid = 1'b0;
      if (o_mem_wenable) begin
        we_cnt++; we_cyc = cyc; w_addr = o_mem_addr; w_data = o_mem_wdata;
      end
      if (o_rsp_valid) begin
        rsp_cyc = cyc; rdata = o_rsp_rdata; err = o_rsp_err;
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    #1;
    checks++; if (o_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", o_req_ready); end
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", o_rsp_valid); end
    checks++; if (o_rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", o_rsp_rdata); end
    checks++; if (o_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", o_rsp_err); end
    checks++; if (o_mem_addr !== 8'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", o_mem_addr); end
    checks++; if (o_mem_wenable !== 1'b0) begin errors++; $display("FAIL reset_wenable: got %b want 0", o_mem_wenable); end
    checks++; if (o_mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", o_mem_wdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    logic [AW+1:0] addrs [7];
    logic [1:0]    sizes [7];
    logic          unss  [7];
    logic [31:0]   exps  [7];
    int rc, wc, wn; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa;
    addrs = '{10'h015, 10'h015, 10'h016, 10'h014, 10'h017, 10'h014, 10'h016};
    sizes = '{2'b00,   2'b00,   2'b01,   2'b01,   2'b00,   2'b00,   2'b00};
    unss  = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1};
    exps  = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB,
              32'hFFFFFF88, 32'hFFFFFFBB, 32'h00000099};
    poke(8'd5, 32'h8899AABB);
    for (int i = 0; i < 7; i++) begin
      run_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, rc, rd, er, wc, wn, wa, wd);
      checks++; if (rd !== exps[i]) begin errors++; $display("FAIL load_rdata[%0d]: got %h want %h", i, rd, exps[i]); end
      checks++; if (rc !== 2) begin errors++; $display("FAIL load_latency[%0d]: got %0d want 2", i, rc); end
      checks++; if (wn !== 0 || er !== 1'b0) begin errors++; $display("FAIL load_no_write[%0d]: writes %0d err %b want 0 0", i, wn, er); end
    end
  endtask

  task automatic test_store_subword();
    int rc, wc, wn; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa;
    poke(8'd5, 32'h8899AABB);
    run_req(1'b1, 2'b01, 1'b0, 10'h016, 32'hFFFF1234, rc, rd, er, wc, wn, wa, wd);
    checks++; if (wc !== 2 || wn !== 1) begin errors++; $display("FAIL sh_wenable: cycle %0d count %0d want 2 1", wc, wn); end
    checks++; if (wa !== 8'd5) begin errors++; $display("FAIL sh_mem_addr: got %h want 05", wa); end
    checks++; if (wd !== 32'h1234AABB) begin errors++; $display("FAIL sh_mem_wdata: got %h want 1234aabb", wd); end
    checks++; if (rc !== 3 || rd !== 32'h0) begin errors++; $display("FAIL sh_response: cycle %0d rdata %h want 3 0", rc, rd); end
    run_req(1'b0, 2'b10, 1'b0, 10'h014, 32'h0, rc, rd, er, wc, wn, wa, wd);
    checks++; if (rd !== 32'h1234AABB) begin errors++; $display("FAIL sh_readback: got %h want 1234aabb", rd); end
    run_req(1'b1, 2'b00, 1'b0, 10'h015, 32'h777777A5, rc, rd, er, wc, wn, wa, wd);
    checks++; if (wd !== 32'h1234A5BB || rc !== 3) begin errors++; $display("FAIL sb_off1: wdata %h cycle %0d want 1234a5bb 3", wd, rc); end
    run_req(1'b1, 2'b00, 1'b0, 10'h017, 32'h0000003C, rc, rd, er, wc, wn, wa, wd);
    checks++; if (wd !== 32'h3C34A5BB) begin errors++; $display("FAIL sb_off3: wdata %h want 3c34a5bb", wd); end
    checks++; if (mem[5] !== 32'h3C34A5BB) begin errors++; $display("FAIL sb_mem_word: got %h want 3c34a5bb", mem[5]); end
  endtask

  task automatic test_store_word();
    int rc, wc, wn; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa;
    run_req(1'b1, 2'b10, 1'b0, 10'h020, 32'hDEADBEEF, rc, rd, er, wc, wn, wa, wd);
    checks++; if (wc !== 1 || wn !== 1) begin errors++; $display("FAIL sw_wenable: cycle %0d count %0d want 1 1", wc, wn); end
    checks++; if (wa !== 8'd8 || wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_write: addr %h data %h want 08 deadbeef", wa, wd); end
    checks++; if (rc !== 2 || rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_response: cycle %0d rdata %h err %b want 2 0 0", rc, rd, er); end
    checks++; if (mem[8] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem_word: got %h want deadbeef", mem[8]); end
  endtask

  task automatic test_backpressure();
    int rc, wc, wn; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa;
    poke(8'd7, 32'h00C0FFEE);
    i_rsp_ready = 1'b0;
    run_req(1'b0, 2'b10, 1'b0, 10'h01C, 32'h0, rc, rd, er, wc, wn, wa, wd);
    checks++; if (rc !== 2 || rd !== 32'h00C0FFEE) begin errors++; $display("FAIL bp_first: cycle %0d rdata %h want 2 00c0ffee", rc, rd); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'b10; i_req_addr = 10'h01C; i_req_wdata = 32'h0;
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'h00C0FFEE || o_req_ready !== 1'b0 || o_mem_wenable !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid %b rdata %h ready %b we %b want 1 00c0ffee 0 0",
                 i, o_rsp_valid, o_rsp_rdata, o_req_ready, o_mem_wenable);
      end
    end
    @(negedge clk);
    i_req_valid = 1'b0; i_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: ready %b valid %b want 1 0", o_req_ready, o_rsp_valid); end
    checks++; if (mem[7] !== 32'h00C0FFEE) begin errors++; $display("FAIL bp_ignored_store: got %h want 00c0ffee", mem[7]); end
  endtask

  task automatic test_back_to_back();
    int rc, wc, wn; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa;
    run_req(1'b0, 2'b00, 1'b1, 10'h022, 32'h0, rc, rd, er, wc, wn, wa, wd);
    checks++; if (rd !== 32'h000000AD) begin errors++; $display("FAIL b2b_first: got %h want 000000ad", rd); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_ready: ready %b valid %b want 1 0", o_req_ready, o_rsp_valid); end
    run_req(1'b0, 2'b01, 1'b0, 10'h020, 32'h0, rc, rd, er, wc, wn, wa, wd);
    checks++; if (rd !== 32'hFFFFBEEF || rc !== 2) begin errors++; $display("FAIL b2b_second: rdata %h cycle %0d want ffffbeef 2", rd, rc); end
  endtask

  task automatic test_reset_mid();
    poke(8'd3, 32'h01020304);
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'b00; i_req_unsigned = 1'b0;
    i_req_addr = 10'h00C; i_req_wdata = 32'h000000EE;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    checks++; if (o_mem_wenable !== 1'b0 || o_mem_addr !== 8'd3) begin errors++; $display("FAIL rst_rmw_cycle: we %b addr %h want 0 03", o_mem_wenable, o_mem_addr); end
    @(negedge clk);
    checks++; if (o_mem_wenable !== 1'b1 || o_mem_wdata !== 32'h010203EE) begin errors++; $display("FAIL rst_write_cycle: we %b wdata %h want 1 010203ee", o_mem_wenable, o_mem_wdata); end
    rst_n = 1'b0;
    #1;
    checks++; if (o_mem_wenable !== 1'b0) begin errors++; $display("FAIL rst_wenable_drop: got %b want 0", o_mem_wenable); end
    checks++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b0 ||
        o_mem_addr !== 8'h0 || o_mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_outputs: ready %b valid %b rdata %h err %b addr %h wdata %h want 1 0 0 0 0 0",
               o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_mem_addr, o_mem_wdata);
    end
    @(posedge clk);
    @(negedge clk);
    checks++; if (mem[3] !== 32'h01020304) begin errors++; $display("FAIL rst_mem_kept: got %h want 01020304", mem[3]); end
    rst_n = 1'b1;
  endtask

  task automatic test_misalign();
    int rc, wc, wn; logic [31:0] rd, wd; logic er; logic [AW-1:0] wa;
    poke(8'd4, 32'hCAFEF00D);
    run_req(1'b0, 2'b10, 1'b0, 10'h013, 32'h0, rc, rd, er, wc, wn, wa, wd);
`ifdef LSU_MISALIGN_ERR_EN
    checks++; if (rc !== 1 || er !== 1'b1 || rd !== 32'h0 || wn !== 0) begin errors++; $display("FAIL mis_word: cycle %0d err %b rdata %h writes %0d want 1 1 0 0", rc, er, rd, wn); end
`else
    checks++; if (rc !== 2 || er !== 1'b0 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_word: cycle %0d err %b rdata %h want 2 0 cafef00d", rc, er, rd); end
`endif
    run_req(1'b0, 2'b01, 1'b0, 10'h013, 32'h0, rc, rd, er, wc, wn, wa, wd);
`ifdef LSU_MISALIGN_ERR_EN
    checks++; if (rc !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_half_load: cycle %0d err %b rdata %h want 1 1 0", rc, er, rd); end
`else
    checks++; if (rc !== 2 || er !== 1'b0 || rd !== 32'hFFFFCAFE) begin errors++; $display("FAIL mis_half_load: cycle %0d err %b rdata %h want 2 0 ffffcafe", rc, er, rd); end
`endif
    run_req(1'b1, 2'b01, 1'b0, 10'h011, 32'h00005555, rc, rd, er, wc, wn, wa, wd);
`ifdef LSU_MISALIGN_ERR_EN
    checks++; if (wn !== 0 || er !== 1'b1 || mem[4] !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_half_store: writes %0d err %b mem %h want 0 1 cafef00d", wn, er, mem[4]); end
`else
    checks++; if (wn !== 1 || er !== 1'b0 || mem[4] !== 32'hCAFE5555) begin errors++; $display("FAIL mis_half_store: writes %0d err %b mem %h want 1 0 cafe5555", wn, er, mem[4]); end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_subword();
    test_store_word();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Byte-addressed load/store front end that sits directly upstream of the word-wide data memory in the multicycle core. It accepts one byte, halfword or word request at a time from the datapath control. It turns each request into word-address memory accesses, and performs read-modify-write for sub-word stores because the memory writes whole words only. Load data is lane-extracted and sign- or zero-extended before it is returned through a valid/ready response port.

Parameters:
ADDR_WIDTH, 8, memory word-address width; byte address is ADDR_WIDTH+2 bits
DATA_WIDTH, 32, data word width; only 32 is supported

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_req_valid  input  1  request valid
o_req_ready  output  1  request accepted when valid&ready at clk edge
i_req_we  input  1  1=store, 0=load
i_req_size  input  2  00 byte, 01 half, 10 word; 11 treated as word
i_req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend
i_req_addr  input  ADDR_WIDTH+2  byte address; [1:0] = byte offset
i_req_wdata  input  32  store data, right-justified
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  response consumed when valid&ready at clk edge
o_rsp_rdata  output  32  load result; 0 for stores
o_rsp_err  output  1  misaligned request (see Optional Feature)
o_mem_addr  output  ADDR_WIDTH  memory word address
o_mem_wenable  output  1  memory word write enable
o_mem_wdata  output  32  memory write data
i_mem_rdata  input  32  memory read data, combinational from o_mem_addr

Behaviour:
- Bit 0 is the LSB throughout this spec. Byte offset b maps to data bits [8b+7:8b]. Half offset 0 maps to [15:0]; half offset 2 maps to [31:16].
- Reset (async, immediate): state IDLE; o_req_ready=1, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_mem_addr=0, o_mem_wenable=0, o_mem_wdata=0; all latched request registers=0.
- States: IDLE, LOAD, RMW, STORE, RESP. o_req_ready=1 only in IDLE. One request is outstanding at most.
- IDLE: on accept, latch we/size/unsigned/addr/wdata. o_mem_addr <= addr[ADDR_WIDTH+1:2]. Next state:
  - load -> LOAD
  - word store -> STORE, with o_mem_wdata <= wdata
  - byte/half store -> RMW
- LOAD: sample i_mem_rdata, extract lane, extend per size/unsigned, register into o_rsp_rdata -> RESP.
- RMW: sample i_mem_rdata and replace the addressed lane with wdata[7:0] (byte) or wdata[15:0] (half). Other lanes are kept. Register the result into o_mem_wdata -> STORE.
- STORE: o_mem_wenable=1 for exactly this one cycle (registered, glitch-free) -> RESP. o_rsp_rdata=0.
- RESP: o_rsp_valid=1. rdata and err are held stable until i_rsp_ready. On handshake -> IDLE and o_rsp_valid=0 the next cycle.
- Latency, with cycle 0 = accept cycle:
  - load: LOAD in cycle 1, o_rsp_valid in cycle 2
  - word store: write in cycle 1, o_rsp_valid in cycle 2
  - sub-word store: read in cycle 1, write in cycle 2, o_rsp_valid in cycle 3
- With i_rsp_ready held high, the next request can be accepted at the earliest one cycle after the response handshake.
- o_mem_wenable is never asserted outside STORE. o_mem_addr is stable from accept until return to IDLE.
- Reset mid-operation: the access is abandoned and wenable drops immediately. A store not yet in STORE never writes memory.
- Loads never write. Sub-word stores write the full word with merged data.

Optional Feature:
Macro LSU_MISALIGN_ERR_EN.
- Defined: a half with addr[0]=1 or a word with addr[1:0]!=0 is misaligned.
  - No memory access occurs and wenable stays 0.
  - IDLE -> RESP directly, so o_rsp_valid appears in cycle 1 with o_rsp_err=1 and o_rsp_rdata=0.
  - Aligned requests report o_rsp_err=0.
- Undefined: o_rsp_err is tied 0. Offending low address bits are forced to 0 (half ignores addr[0]; word ignores addr[1:0]), and the request proceeds as aligned.

Test Plan:
1. Memory word 5 = 0x8899AABB; load byte signed addr 0x15 -> o_rsp_rdata=0xFFFFFFAA, o_rsp_valid in cycle 2. Same with unsigned -> 0x000000AA. Half signed addr 0x16 -> 0xFFFF8899.
2. Word 5 = 0x8899AABB; store half 0x1234 to addr 0x16 -> RMW in cycle 1, wenable only in cycle 2 with o_mem_addr=5 and o_mem_wdata=0x1234AABB, o_rsp_valid in cycle 3. A following word load at 0x14 returns 0x1234AABB.
3. Store word 0xDEADBEEF to addr 0x20 -> o_mem_addr=8, wenable in cycle 1 with wdata 0xDEADBEEF, response in cycle 2 with rdata 0.
4. Hold i_rsp_ready=0 for 5 cycles after a load -> o_rsp_valid stays 1, rdata stable, o_req_ready=0, and a new i_req_valid is ignored. Raise ready -> handshake, o_req_ready=1 the next cycle.
5. Pulse rst_n low in the write cycle of a byte store to word 3 (=0x01020304) -> wenable falls immediately, word 3 stays 0x01020304, and all outputs take their reset values.
6. Word load at addr 0x13 with word 4 = 0xCAFEF00D:
   - Macro defined -> o_rsp_valid in cycle 1, o_rsp_err=1, rdata 0, no memory access.
   - Macro undefined -> rdata 0xCAFEF00D, err 0.
